keypad_scan_mux: RTL

Parametrised keypad front end: scans a ROWS x COLS matrix, debounces presses and releases, and emits one strobe per key. Keeps a shift history of the last NUM_DIGITS key codes and time-multiplexes them onto a shared digit bus with one-hot digit enables. Sits between the top-level HSOSC clock and the external hex/seven-segment decoder, replacing the fixed 4x4, two-digit scanner and clock-divider logic.

---
 rtl/keypad_scan_mux.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_mux.sv
// keypad_scan_mux
//   Keypad front end for a ROWS x COLS switch matrix. Walks an active-low
//   column strobe across the matrix, debounces presses and releases, and
//   emits a one-cycle strobe per accepted key. The last NUM_DIGITS key codes
//   are kept in a shift history. That history is time-multiplexed onto a
//   shared digit bus with one-hot digit enables for an external decoder.
//
//   Optional build macro:
//     KEY_REPEAT_EN - while a key is held, re-emit it every REPEAT_SCANS ticks
//
// Ports
//   int_osc   : system clock
//   reset     : synchronous, active-high reset
//   row       : keypad rows, active-low, asynchronous (2-flop synchronised)
//   cols      : column drive, active-low, exactly one bit low
//   key_code  : last accepted code, row_idx*COLS + col_idx
//   key_valid : one-cycle strobe when a code is accepted
//   digits    : code history, [KW-1:0] is the most recent entry
//   dig_sel   : one-hot digit enable, active-high
//   dig_val   : history entry for the currently enabled digit

module keypad_scan_mux #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int DEB_SCANS    = 20,
  parameter int NUM_DIGITS   = 2,
  parameter int MUX_DIV      = 100000,
  parameter int REPEAT_SCANS = 50,
  localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic                     int_osc,
  input  logic                     reset,
  input  logic [ROWS-1:0]          row,
  output logic [COLS-1:0]          cols,
  output logic [KW-1:0]            key_code,
  output logic                     key_valid,
  output logic [NUM_DIGITS*KW-1:0] digits,
  output logic [NUM_DIGITS-1:0]    dig_sel,
  output logic [KW-1:0]            dig_val
);

  localparam int RW = (ROWS > 1)       ? $clog2(ROWS)       : 1;
  localparam int CW = (COLS > 1)       ? $clog2(COLS)       : 1;
  localparam int SW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int MW = (MUX_DIV > 1)    ? $clog2(MUX_DIV)    : 1;
  localparam int DW = (DEB_SCANS > 1)  ? $clog2(DEB_SCANS)  : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  if (ROWS < 1 || COLS < 1 || SCAN_DIV < 1 || DEB_SCANS < 1 ||
      NUM_DIGITS < 1 || MUX_DIV < 1 || REPEAT_SCANS < 1) begin : g_param_check
    $error("keypad_scan_mux: all size and divider parameters must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Row synchroniser
  // ---------------------------------------------------------------------------
  logic [ROWS-1:0] row_meta;
  logic [ROWS-1:0] row_sync;

  always_ff @(posedge int_osc) begin
    if (reset) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan tick prescaler
  // ---------------------------------------------------------------------------
  logic [SW-1:0] presc;
  logic          tick;

  assign tick = (presc == SW'(SCAN_DIV - 1));

  always_ff @(posedge int_osc) begin
    if (reset)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Scan / debounce state machine
  // ---------------------------------------------------------------------------
  logic [1:0]    state, state_n;
  logic [CW-1:0] col_idx, col_n, col_inc;
  logic [RW-1:0] cap_row, cap_n;
  logic [DW-1:0] cnt, cnt_n;
  logic          any_low;
  logic [RW-1:0] low_idx;
  logic          cap_low;
  logic          shift;
  logic [RW-1:0] shift_row;
  logic [KW-1:0] shift_code;
  logic [NUM_DIGITS-1:0][KW-1:0] hist;

`ifdef KEY_REPEAT_EN
  localparam int PW = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
  logic [PW-1:0] rep_cnt, rep_n;
`endif

  assign cols    = ~(COLS'(1) << col_idx);
  assign col_inc = (col_idx == CW'(COLS - 1)) ? '0 : col_idx + 1'b1;
  assign cap_low = ~row_sync[cap_row];

  // Lowest-index low row wins when several rows are pressed together.
  always_comb begin
    any_low = 1'b0;
    low_idx = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (!row_sync[i] && !any_low) begin
        any_low = 1'b1;
        low_idx = RW'(i);
      end
    end
  end

  assign shift_code = KW'(int'(shift_row) * COLS + int'(col_idx));

  // Debounce counts stable ticks after the capture tick; the capture tick
  // itself is the first stable one, so acceptance fires when the count would
  // reach DEB_SCANS-1. A single-tick debounce accepts straight from SCAN.
  always_comb begin
    state_n   = state;
    col_n     = col_idx;
    cap_n     = cap_row;
    cnt_n     = cnt;
    shift     = 1'b0;
    shift_row = cap_row;
`ifdef KEY_REPEAT_EN
    rep_n     = rep_cnt;
`endif
    if (tick) begin
      case (state)
        ST_SCAN: begin
          shift_row = low_idx;
          if (any_low) begin
            cap_n = low_idx;
            cnt_n = '0;
            if (DEB_SCANS == 1) begin
              shift   = 1'b1;
              state_n = ST_HELD;
            end else begin
              state_n = ST_DEBOUNCE;
            end
          end else begin
            col_n = col_inc;
          end
        end
        ST_DEBOUNCE: begin
          if (cap_low) begin
            if (cnt == DW'(DEB_SCANS - 2)) begin
              shift   = 1'b1;
              cnt_n   = '0;
              state_n = ST_HELD;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            state_n = ST_SCAN;
            col_n   = col_inc;
          end
        end
        ST_HELD: begin
          if (!cap_low) begin
            cnt_n = '0;
            if (DEB_SCANS == 1) begin
              state_n = ST_SCAN;
              col_n   = col_inc;
            end else begin
              state_n = ST_RELEASE;
            end
          end
`ifdef KEY_REPEAT_EN
          else begin
            // A repeat that would land right after a strobe waits a tick.
            if (rep_cnt == PW'(REPEAT_SCANS - 1)) begin
              if (!key_valid) begin
                shift = 1'b1;
                rep_n = '0;
              end
            end else begin
              rep_n = rep_cnt + 1'b1;
            end
          end
`endif
        end
        default: begin // ST_RELEASE
          if (!cap_low) begin
            if (cnt == DW'(DEB_SCANS - 2)) begin
              state_n = ST_SCAN;
              col_n   = col_inc;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            state_n = ST_HELD;
          end
        end
      endcase
    end
`ifdef KEY_REPEAT_EN
    if (state_n == ST_HELD && state != ST_HELD) rep_n = '0;
`endif
  end

  always_ff @(posedge int_osc) begin
    if (reset) begin
      state     <= ST_SCAN;
      col_idx   <= '0;
      cap_row   <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      hist      <= '0;
    end else begin
      state     <= state_n;
      col_idx   <= col_n;
      cap_row   <= cap_n;
      cnt       <= cnt_n;
      key_valid <= shift;
      if (shift) begin
        key_code <= shift_code;
        hist[0]  <= shift_code;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
          hist[i] <= hist[i-1];
        end
      end
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge int_osc) begin
    if (reset) rep_cnt <= '0;
    else       rep_cnt <= rep_n;
  end
`endif

  assign digits = hist;

  // ---------------------------------------------------------------------------
  // Display multiplexer
  // ---------------------------------------------------------------------------
  logic [MW-1:0] mux_cnt;
  logic [IW-1:0] mux_idx;
  logic          mux_wrap;

  assign mux_wrap = (mux_cnt == MW'(MUX_DIV - 1));

  // dig_sel/dig_val are registered from mux_idx and hist, so both follow a
  // slot change or a history shift one cycle later and always stay paired.
  always_ff @(posedge int_osc) begin
    if (reset) begin
      mux_cnt <= '0;
      mux_idx <= '0;
      dig_sel <= NUM_DIGITS'(1);
      dig_val <= '0;
    end else begin
      if (mux_wrap) begin
        mux_cnt <= '0;
        mux_idx <= (mux_idx == IW'(NUM_DIGITS - 1)) ? '0 : mux_idx + 1'b1;
      end else begin
        mux_cnt <= mux_cnt + 1'b1;
      end
      dig_sel <= NUM_DIGITS'(1) << mux_idx;
      dig_val <= hist[mux_idx];
    end
  end

endmodule
